// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// register addresses, STATUS bit positions and the transmit FSM state type.
package mmio_pkg;

  localparam logic [31:0] UART_TXDATA = 32'h4000_0018;
  localparam logic [31:0] UART_STATUS = UART_TXDATA + 32'd4;

  localparam int ST_BUSY     = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_EMPTY    = 2;
  localparam int ST_OVERFLOW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head entry.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MEM-stage responder: stores to TXDATA queue bytes, an FSM sends them 8N1
// LSB-first on tx, and loads from STATUS report FIFO/transmitter state.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = UART_TXDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic        tx
);

  localparam int              CPB       = CLK_FREQ / BAUD;
  localparam int              BW        = $clog2(CPB);
  localparam int              CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CPB - 1);

  tx_state_t      r_state;
  logic [BW-1:0]  r_baud;
  logic [2:0]     r_bit;
  logic [7:0]     r_shreg;
  logic           r_overflow;
  logic           r_tx;

  logic           w_sel_data;
  logic           w_sel_stat;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic [7:0]     w_head;
  logic           w_unused;

  assign w_sel_data = (Address == BASE_ADDR);
  assign w_sel_stat = (Address == BASE_ADDR + 32'd4);
  assign hit        = w_sel_data || w_sel_stat;
  assign w_push     = MemWrite && w_sel_data && !w_full;
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign tx         = r_tx;
  assign w_unused   = ^Write_data[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (Write_data[7:0]),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    Read_data = '0;
    if (w_sel_stat) begin
      Read_data[15:8]        = 8'(w_count);
      Read_data[ST_OVERFLOW] = r_overflow;
      Read_data[ST_EMPTY]    = w_empty;
      Read_data[ST_FULL]     = w_full;
      Read_data[ST_BUSY]     = (r_state != IDLE);
    end
  end

  // tx is registered from the state, so each level appears one edge after
  // the state that owns it; the baud counter restarts at every bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shreg    <= '0;
      r_overflow <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      if (MemWrite && w_sel_data && w_full) begin
        r_overflow <= 1'b1;
      end else if (MemRead && w_sel_stat) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shreg <= w_head;
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          r_tx <= r_shreg[0];
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_shreg <= {1'b0, r_shreg[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
